// File: rtl/text_buffer_pkg.sv
// Shared types and defaults for the text buffer arbiter and its character RAM.
package text_buffer_pkg;
   localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;
   localparam int         DEPTH_DEFAULT     = 64;

   typedef enum logic {IDLE, CLEAR} state_e;
   typedef enum logic {GRANT_A, GRANT_B} grant_e;
endpackage

// File: rtl/text_buffer_arbiter_char_ram.sv
// DEPTH x 8 character store: one write port, one registered read port (1 cycle),
// read-before-write on a same-cell collision; contents are not reset.
module char_ram #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);
   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/text_buffer_arbiter.sv
// Two-writer round-robin character buffer with a fill sweep after reset/on request.
// Readys are combinational (same-cycle accept); read port returns data 1 cycle later.
module text_buffer_arbiter
   import text_buffer_pkg::*;
#(
   parameter int         DEPTH     = DEPTH_DEFAULT,
   parameter int         ADDR_W    = 6,
   parameter logic [7:0] FILL_CHAR = FILL_CHAR_DEFAULT
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              reqA_valid_i,
   input  logic [ADDR_W-1:0] reqA_addr_i,
   input  logic [7:0]        reqA_char_i,
   output logic              reqA_ready_o,
   input  logic              reqB_valid_i,
   input  logic [ADDR_W-1:0] reqB_addr_i,
   input  logic [7:0]        reqB_char_i,
   output logic              reqB_ready_o,
   input  logic              clear_i,
   output logic              busy_o,
   input  logic [ADDR_W-1:0] charAddress_i,
   output logic [7:0]        charData_o
);
   state_e            state_q, state_d;
   grant_e            last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] clear_cnt_q, clear_cnt_d;
   logic              rd_vld_q, rd_vld_d;
   logic              grant_a, grant_b;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      clear_cnt_d  = clear_cnt_q;
      rd_vld_d     = 1'b1;
      grant_a      = 1'b0;
      grant_b      = 1'b0;
      ram_we       = 1'b0;
      ram_waddr    = clear_cnt_q;
      ram_wdata    = FILL_CHAR;
      case (state_q)
         CLEAR: begin
            ram_we      = 1'b1;
            clear_cnt_d = clear_cnt_q + 1'b1;
            if (clear_cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
         end
         IDLE: begin
            if (clear_i) begin
               state_d     = CLEAR;
               clear_cnt_d = '0;
            end else begin
               // On a tie the requester that did not win last time goes first.
               grant_a = reqA_valid_i && (!reqB_valid_i || last_grant_q == GRANT_B);
               grant_b = reqB_valid_i && (!reqA_valid_i || last_grant_q == GRANT_A);
               if (grant_a) begin
                  ram_we       = 1'b1;
                  ram_waddr    = reqA_addr_i;
                  ram_wdata    = reqA_char_i;
                  last_grant_d = GRANT_A;
               end else if (grant_b) begin
                  ram_we       = 1'b1;
                  ram_waddr    = reqB_addr_i;
                  ram_wdata    = reqB_char_i;
                  last_grant_d = GRANT_B;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= CLEAR;
         last_grant_q <= GRANT_B;
         clear_cnt_q  <= '0;
         rd_vld_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         clear_cnt_q  <= clear_cnt_d;
         rd_vld_q     <= rd_vld_d;
      end
   end

   char_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_char_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (charAddress_i),
      .rdata_o (ram_rdata)
   );

   assign reqA_ready_o = grant_a;
   assign reqB_ready_o = grant_b;
   assign busy_o       = (state_q == CLEAR);
   // The RAM has no reset, so the read output shows FILL_CHAR until its first registered read.
   assign charData_o   = rd_vld_q ? ram_rdata : FILL_CHAR;
endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Directed bench for text_buffer_arbiter with a cycle-level reference model.
module tb_text_buffer_arbiter;
   localparam logic [7:0] FILL = 8'h20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_vld, b_vld, a_rdy, b_rdy, clr, busy;
   logic [5:0] a_addr, b_addr, rd_addr;
   logic [7:0] a_chr, b_chr, rd_dat;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   int         m_sweep;
   int         m_idx;
   bit         m_last_a;
   logic [7:0] m_mem [64];
   bit         m_known [64];
   logic [7:0] m_rd;
   bit         m_rd_known;

   always #5 clk = ~clk;

   text_buffer_arbiter dut (
      .clk_i         (clk),
      .reset_ni      (rst_n),
      .reqA_valid_i  (a_vld),
      .reqA_addr_i   (a_addr),
      .reqA_char_i   (a_chr),
      .reqA_ready_o  (a_rdy),
      .reqB_valid_i  (b_vld),
      .reqB_addr_i   (b_addr),
      .reqB_char_i   (b_chr),
      .reqB_ready_o  (b_rdy),
      .clear_i       (clr),
      .busy_o        (busy),
      .charAddress_i (rd_addr),
      .charData_o    (rd_dat)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: a sweep is DEPTH write cycles; idle cycles honour clear, then round-robin writes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sweep    = 64;
         m_idx      = 0;
         m_last_a   = 1'b0;
         m_rd       = FILL;
         m_rd_known = 1'b1;
      end else begin
         m_rd       = m_mem[rd_addr];
         m_rd_known = m_known[rd_addr];
         if (m_sweep > 0) begin
            m_mem[m_idx]   = FILL;
            m_known[m_idx] = 1'b1;
            m_idx          = (m_idx + 1) % 64;
            m_sweep        = m_sweep - 1;
         end else if (clr) begin
            m_sweep = 64;
            m_idx   = 0;
         end else if (a_vld && (!b_vld || !m_last_a)) begin
            m_mem[a_addr]   = a_chr;
            m_known[a_addr] = 1'b1;
            m_last_a        = 1'b1;
         end else if (b_vld) begin
            m_mem[b_addr]   = b_chr;
            m_known[b_addr] = 1'b1;
            m_last_a        = 1'b0;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      bit e_busy, e_a, e_b;
      e_busy = (m_sweep > 0);
      e_a    = !e_busy && !clr && a_vld && (!b_vld || !m_last_a);
      e_b    = !e_busy && !clr && b_vld && (!a_vld || m_last_a);
      chk("model_busy", busy, e_busy);
      chk("model_ready_a", a_rdy, e_a);
      chk("model_ready_b", b_rdy, e_b);
      if (m_rd_known) chk("model_char_data", rd_dat, m_rd);
   end

   task automatic count_busy(input string nm, input bit watch_a, input bit watch_b);
      int cnt = 0;
      while (busy && cnt < 200) begin
         if (watch_a) chk({nm, "_ready_a_low"}, a_rdy, 1'b0);
         if (watch_b) chk({nm, "_ready_b_low"}, b_rdy, 1'b0);
         @(posedge clk); #1;
         cnt++;
      end
      chk({nm, "_busy_cycles"}, cnt, 64);
   endtask

   task automatic rd_chk(input string nm, input logic [5:0] addr, input logic [7:0] exp);
      rd_addr = addr;
      @(posedge clk); #1;
      chk(nm, rd_dat, exp);
   endtask

   task automatic wr(input bit is_a, input logic [5:0] addr, input logic [7:0] chr);
      int cnt = 0;
      if (is_a) begin a_vld = 1; a_addr = addr; a_chr = chr; end
      else      begin b_vld = 1; b_addr = addr; b_chr = chr; end
      @(negedge clk);
      while (!(is_a ? a_rdy : b_rdy) && cnt < 100) begin @(negedge clk); cnt++; end
      chk("write_accept_timeout", cnt < 100, 1'b1);
      @(posedge clk); #1;
      if (is_a) a_vld = 0; else b_vld = 0;
   endtask

   initial begin
      int ka, kb;
      bit ga, gb;
      for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
      a_vld = 0; b_vld = 0; clr = 0;
      a_addr = 0; b_addr = 0; a_chr = 0; b_chr = 0; rd_addr = 0;
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 1'b1);
      chk("reset_char_data", rd_dat, FILL);
      chk("reset_ready_a", a_rdy, 1'b0);

      // Post-reset sweep with A already pending: A must wait out all 64 cycles
      a_vld = 1; a_addr = 6'd5; a_chr = 8'h48;
      rst_n = 1;
      count_busy("post_reset", 1'b1, 1'b0);
      chk("single_write_ready_same_cycle", a_rdy, 1'b1);
      @(posedge clk); #1;
      a_vld = 0;
      rd_chk("single_write_readback", 6'd5, 8'h48);
      rd_chk("sweep_cell0", 6'd0, FILL);
      rd_chk("sweep_cell31", 6'd31, FILL);
      rd_chk("sweep_cell63", 6'd63, FILL);

      // One B write so A is next in line for the contention burst
      wr(1'b0, 6'd20, 8'h55);

      a_vld = 1; a_addr = 6'd1;  a_chr = 8'h61; ka = 0;
      b_vld = 1; b_addr = 6'd10; b_chr = 8'h71; kb = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         ga = a_rdy; gb = b_rdy;
         chk("contention_grant_order", {ga, gb}, (i % 2 == 0) ? 2'b10 : 2'b01);
         @(posedge clk); #1;
         if (ga) begin
            ka++;
            if (ka < 3) begin a_addr = 6'(1 + ka); a_chr = 8'(8'h61 + ka); end
            else a_vld = 0;
         end
         if (gb) begin
            kb++;
            if (kb < 3) begin b_addr = 6'(10 + kb); b_chr = 8'(8'h71 + kb); end
            else b_vld = 0;
         end
      end
      chk("contention_a_count", ka, 3);
      chk("contention_b_count", kb, 3);
      rd_chk("contention_cell1", 6'd1, 8'h61);
      rd_chk("contention_cell2", 6'd2, 8'h62);
      rd_chk("contention_cell3", 6'd3, 8'h63);
      rd_chk("contention_cell10", 6'd10, 8'h71);
      rd_chk("contention_cell11", 6'd11, 8'h72);
      rd_chk("contention_cell12", 6'd12, 8'h73);

      // Clear and B arrive together: clear wins, B waits for the whole sweep
      clr = 1; b_vld = 1; b_addr = 6'd40; b_chr = 8'h5A;
      #1;
      chk("clear_priority_ready_b", b_rdy, 1'b0);
      chk("clear_priority_not_busy_yet", busy, 1'b0);
      @(posedge clk); #1;
      clr = 0;
      count_busy("clear_sweep", 1'b0, 1'b1);
      chk("clear_then_b_granted", b_rdy, 1'b1);
      @(posedge clk); #1;
      b_vld = 0;
      for (int i = 0; i < 64; i++)
         rd_chk("after_clear_cell", 6'(i), (i == 40) ? 8'h5A : FILL);

      // Read/write collision on cell 10
      wr(1'b1, 6'd10, 8'h41);
      a_vld = 1; a_addr = 6'd10; a_chr = 8'h42; rd_addr = 6'd10;
      @(posedge clk); #1;
      a_vld = 0;
      chk("collision_old_value", rd_dat, 8'h41);
      @(posedge clk); #1;
      chk("collision_new_value", rd_dat, 8'h42);

      // Reset in the middle of a sweep (clearCount=30)
      clr = 1;
      @(posedge clk); #1;
      clr = 0;
      repeat (30) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      chk("mid_sweep_reset_busy", busy, 1'b1);
      chk("mid_sweep_reset_char_data", rd_dat, FILL);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      count_busy("mid_sweep_restart", 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
      $fatal(1);
   end
endmodule

// File: doc/text_buffer_arbiter.md
Name: text_buffer_arbiter

Overview:
- Character buffer shared between two writers, e.g. a UART console and an on-chip status generator, and one reader, the text engine that feeds the OLED screen driver.
- Stores DEPTH 8-bit character codes, 4 rows x 16 columns by default.
- Arbitrates writes round-robin with valid/ready handshakes.
- Runs a fill-with-space clear sweep after reset and on request.
- Gives the text engine a synchronous read port with 1-cycle latency.

Parameters:
- DEPTH, 64: number of character cells; must be a power of two.
- ADDR_W, 6: address width; equals log2(DEPTH).
- FILL_CHAR, 8'h20: code written to every cell by a clear sweep (ASCII space).

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- reqA_valid_i  in  1  requester A has a write pending
- reqA_addr_i  in  ADDR_W  requester A cell address
- reqA_char_i  in  8  requester A character code
- reqA_ready_o  out  1  requester A write accepted this cycle
- reqB_valid_i  in  1  requester B has a write pending
- reqB_addr_i  in  ADDR_W  requester B cell address
- reqB_char_i  in  8  requester B character code
- reqB_ready_o  out  1  requester B write accepted this cycle
- clear_i  in  1  single-cycle pulse: start a clear sweep
- busy_o  out  1  clear sweep in progress
- charAddress_i  in  ADDR_W  text engine read address
- charData_o  out  8  character at charAddress_i, 1 cycle later

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clearCount=0, lastGrant=B, busy_o=1, charData_o=FILL_CHAR. Ready outputs are combinational and are 0 whenever state=CLEAR.
- State CLEAR:
  - Each cycle writes FILL_CHAR to cell clearCount, then clearCount++.
  - When clearCount==DEPTH-1 is written, go to IDLE next cycle; busy_o drops with the transition.
  - Exactly DEPTH write cycles per sweep.
  - clear_i is ignored during CLEAR; the sweep does not restart.
  - reqX_ready_o=0 throughout.
- State IDLE:
  - If clear_i=1: go to CLEAR and set clearCount=0. No grant that cycle; both readys are 0. Clear wins over requests.
  - Else if only one valid: that requester's ready=1 combinationally in the same cycle.
  - Else if both valid: grant the requester not equal to lastGrant. The first tie after reset goes to A.
  - A transfer occurs on valid&&ready. Write the char to the addressed cell at the clock edge and update lastGrant to the winner.
  - Ready never asserts without the matching valid. At most one ready per cycle.
- Requester rules: valid must stay high with addr and char stable until ready. A requester may deassert valid only after a transfer. The block does not check for violations.
- Read port:
  - charData_o <= mem[charAddress_i] on every clock edge, in all states.
  - Read-before-write: if the same cell is written in the same cycle, charData_o returns the old value and the new value appears on the following read.
  - During CLEAR, reads return a mix of old and FILL_CHAR values; the text engine tolerates this.
- Addresses wrap naturally, since DEPTH=2^ADDR_W; no out-of-range case exists.
- Reset mid-sweep: the sweep restarts from cell 0 and busy_o stays high for a full DEPTH cycles after release.
- Cell contents are not reset directly; they are defined only by the post-reset sweep.

Decomposition:
- Package text_buffer_pkg holds:
  - FILL_CHAR_DEFAULT = 8'h20
  - DEPTH_DEFAULT = 64
  - state enum {IDLE, CLEAR}
  - grant enum {GRANT_A, GRANT_B}
- Sub-module char_ram: DEPTH x 8, one synchronous write port, one synchronous read port, read-before-write, no reset. Infers BSRAM or LUT-RAM.
- Arbiter, clear counter and FSM live in text_buffer_arbiter.

Test Plan:
- Post-reset sweep: release reset_ni and idle.
  - Required: busy_o=1 for exactly 64 cycles, both readys 0 while reqA_valid_i=1.
  - Required: afterwards, reads of addr 0, 31, 63 return 8'h20.
- Single write: A valid, addr 5, char 8'h48 in IDLE.
  - Required: reqA_ready_o=1 in the same cycle.
  - Required: charAddress_i=5 on the next cycle yields charData_o=8'h48 one cycle later.
- Contention: A and B hold valid continuously for 6 transfers, A to addr 1..3 and B to addr 10..12.
  - Required: grants A,B,A,B,A,B.
  - Required: cells 1..3 and 10..12 hold the written codes.
- Clear priority: clear_i and reqB_valid_i both high in the same IDLE cycle.
  - Required: reqB_ready_o=0 and busy_o=1 for 64 cycles, then reqB is granted.
  - Required: B's cell holds B's char and all other cells hold 8'h20.
- Reset mid-sweep: assert reset_ni=0 at clearCount=30, release 3 cycles later.
  - Required: busy_o=1 for a full 64 cycles after release.
- Read/write collision: cell 10 holds 8'h41; write 8'h42 to cell 10 while charAddress_i=10.
  - Required: charData_o=8'h41 on the first edge and 8'h42 on the next.
